// File: rtl/sisc_pkg.sv
// sisc_pkg: opcode constants, ALU_OP encodings and sequencer states shared by the sisc_seq block.
package sisc_pkg;
    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_ALU_RR = 4'h1;
    localparam logic [3:0] OP_ALU_RI = 4'h2;
    localparam logic [3:0] OP_BRA    = 4'h4;
    localparam logic [3:0] OP_HALT   = 4'h8;
    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_RR   = 2'b01;
    localparam logic [1:0] ALU_RI   = 2'b10;
    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALT
    } state_t;
endpackage

// File: rtl/pc_unit.sv
// pc_unit: program counter with 16-bit wrapping increment and branch-relative load.
module pc_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_inc,
    input  logic        ld_br,
    input  logic [15:0] offset,
    output logic [15:0] pc
);
    always_ff @(posedge clk) begin
        if (rst) pc <= 16'h0000;
        else if (ld_br) pc <= pc + 16'd1 + offset;
        else if (ld_inc) pc <= pc + 16'd1;
    end
endmodule

// File: rtl/sisc_seq.sv
// sisc_seq: fetch/decode/execute/writeback sequencer driving a simple register-file datapath.
module sisc_seq
    import sisc_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        IM_RDY,
    input  logic [31:0] IM_DATA,
    input  logic [3:0]  STAT,
    output logic        IM_REQ,
    output logic [15:0] PC,
    output logic [31:0] IR,
    output logic        RF_WE,
    output logic [1:0]  ALU_OP,
    output logic        WB_SEL,
    output logic        RD_SEL,
    output logic        STAT_EN,
    output logic        HALTED
);
    state_t state, state_nx;
    logic [3:0] opc;
    logic is_alu, alu_ph, taken, ld_inc, ld_br;
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_FETCH;
            IR    <= '0;
        end else begin
            state <= state_nx;
            if (state == S_FETCH && IM_RDY) IR <= IM_DATA;
        end
    end
    always_comb begin
        state_nx = state;
        case (state)
            S_FETCH:     state_nx = IM_RDY ? S_DECODE : S_FETCH;
            S_DECODE:    state_nx = S_EXECUTE;
            S_EXECUTE:   state_nx = is_alu ? S_WRITEBACK : (opc == OP_HALT) ? S_HALT : S_FETCH;
            S_WRITEBACK: state_nx = S_FETCH;
            S_HALT:      state_nx = S_HALT;
            default:     state_nx = S_FETCH;
        endcase
    end
    assign opc     = IR[31:28];
    assign is_alu  = opc == OP_ALU_RR || opc == OP_ALU_RI;
    assign alu_ph  = is_alu && (state == S_EXECUTE || state == S_WRITEBACK);
    assign taken   = opc == OP_BRA && |(IR[27:24] & STAT);
    // fetch request is masked during reset so memory never sees a request from a stale state
    assign IM_REQ  = state == S_FETCH && !RST;
    assign HALTED  = state == S_HALT;
    assign ALU_OP  = alu_ph ? (opc == OP_ALU_RR ? ALU_RR : ALU_RI) : ALU_PASS;
    assign RD_SEL  = alu_ph && opc == OP_ALU_RR;
    assign STAT_EN = is_alu && state == S_EXECUTE;
    assign RF_WE   = is_alu && state == S_WRITEBACK;
    assign WB_SEL  = RF_WE;
    assign ld_br   = state == S_EXECUTE && taken;
    assign ld_inc  = state == S_WRITEBACK || (state == S_EXECUTE && !is_alu && opc != OP_HALT && !taken);
    pc_unit u_pc (
        .clk   (CLK),
        .rst   (RST),
        .ld_inc(ld_inc),
        .ld_br (ld_br),
        .offset(IR[15:0]),
        .pc    (PC)
    );
endmodule

// File: tb/tb_sisc_seq.sv
// tb_sisc_seq: vector table, directed corner sequences and a randomized program checked against a timeline model.
module tb_sisc_seq;
    logic        CLK, RST, IM_RDY, IM_REQ, RF_WE, WB_SEL, RD_SEL, STAT_EN, HALTED;
    logic [31:0] IM_DATA, IR;
    logic [3:0]  STAT;
    logic [15:0] PC;
    logic [1:0]  ALU_OP;
    int errors = 0, checks = 0;

    sisc_seq dut (
        .CLK(CLK), .RST(RST), .IM_RDY(IM_RDY), .IM_DATA(IM_DATA), .STAT(STAT),
        .IM_REQ(IM_REQ), .PC(PC), .IR(IR), .RF_WE(RF_WE), .ALU_OP(ALU_OP),
        .WB_SEL(WB_SEL), .RD_SEL(RD_SEL), .STAT_EN(STAT_EN), .HALTED(HALTED)
    );

    initial CLK = 0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] instr;
        logic [3:0]  stat;
        int          lat;
        logic [15:0] pc;
        logic        we;
        logic        se;
    } vec_t;
    vec_t tbl[10];

    function automatic logic [23:0] pk(input logic r, input logic [15:0] p, input logic we,
                                       input logic [1:0] a, input logic wb, input logic rd,
                                       input logic se, input logic h);
        return {r, p, we, a, wb, rd, se, h};
    endfunction

    task automatic go();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [23:0] exp);
        logic [23:0] act;
        act = {IM_REQ, PC, RF_WE, ALU_OP, WB_SEL, RD_SEL, STAT_EN, HALTED};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got req/pc/we/alu/wb/rd/se/h=%h required %h", name, act, exp);
        end
    endtask

    task automatic chk_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic rst_seq();
        RST = 1; IM_RDY = 0; STAT = 0; IM_DATA = 0;
        go(); go();
        chk_val("im_req_in_reset", {31'd0, IM_REQ}, 0);
        RST = 0;
        #1;
    endtask

    task automatic run_one(input logic [31:0] instr, input logic [3:0] stat,
                           output int n, output logic we, output logic se);
        rst_seq();
        IM_DATA = instr; STAT = stat; IM_RDY = 1; n = 1; we = 0; se = 0;
        go();
        IM_RDY = 0;
        while (!IM_REQ && n < 10) begin
            we |= RF_WE; se |= STAT_EN;
            n++;
            go();
        end
    endtask

    initial begin
        int n;
        logic we, se;
        logic [3:0]  op, st;
        logic [31:0] r, instr;
        logic [15:0] pc_m;
        logic [1:0]  aop;
        logic        alu;
        tbl[0] = '{32'h1120_3000, 4'h0, 4, 16'h0001, 1'b1, 1'b1};
        tbl[1] = '{32'h2345_6789, 4'hF, 4, 16'h0001, 1'b1, 1'b1};
        tbl[2] = '{32'h4100_0005, 4'h1, 3, 16'h0006, 1'b0, 1'b0};
        tbl[3] = '{32'h4100_0005, 4'h2, 3, 16'h0001, 1'b0, 1'b0};
        tbl[4] = '{32'h0000_0000, 4'h0, 3, 16'h0001, 1'b0, 1'b0};
        tbl[5] = '{32'h7000_1234, 4'hF, 3, 16'h0001, 1'b0, 1'b0};
        tbl[6] = '{32'h4F00_FFFF, 4'h8, 3, 16'h0000, 1'b0, 1'b0};
        tbl[7] = '{32'h4000_0005, 4'hF, 3, 16'h0001, 1'b0, 1'b0};
        tbl[8] = '{32'h3FFF_FFFF, 4'hF, 3, 16'h0001, 1'b0, 1'b0};
        tbl[9] = '{32'hF000_0010, 4'hF, 3, 16'h0001, 1'b0, 1'b0};
        for (int i = 0; i < 10; i++) begin
            run_one(tbl[i].instr, tbl[i].stat, n, we, se);
            chk_val($sformatf("tbl%0d_latency", i), n, tbl[i].lat);
            chk_val($sformatf("tbl%0d_pc", i), {16'd0, PC}, {16'd0, tbl[i].pc});
            chk_val($sformatf("tbl%0d_we_se", i), {30'd0, we, se}, {30'd0, tbl[i].we, tbl[i].se});
        end

        // ALU reg-reg timeline
        rst_seq();
        chk_val("alu_ir_reset", IR, 0);
        chk("alu_c1", pk(1, 0, 0, 2'b00, 0, 0, 0, 0));
        IM_DATA = 32'h1120_3000; IM_RDY = 1;
        go(); IM_RDY = 0;
        chk_val("alu_ir_c1", IR, 32'h1120_3000);
        chk("alu_c2", pk(0, 0, 0, 2'b00, 0, 0, 0, 0));
        go(); chk("alu_c3", pk(0, 0, 0, 2'b01, 0, 1, 1, 0));
        go(); chk("alu_c4", pk(0, 0, 1, 2'b01, 1, 1, 0, 0));
        go(); chk("alu_c5", pk(1, 1, 0, 2'b00, 0, 0, 0, 0));

        // fetch stall
        rst_seq();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall%0d", i), pk(1, 0, 0, 2'b00, 0, 0, 0, 0));
            chk_val($sformatf("stall_ir%0d", i), IR, 0);
            IM_DATA = 32'hDEAD_BEEF;
            go();
        end
        IM_DATA = 32'h2345_0000; IM_RDY = 1;
        go(); IM_RDY = 0;
        chk_val("stall_ir_load", IR, 32'h2345_0000);

        // HALT then reset pulse
        rst_seq();
        IM_DATA = 32'h8000_0000; IM_RDY = 1;
        go(); IM_RDY = 0;
        go(); chk("halt_c3", pk(0, 0, 0, 2'b00, 0, 0, 0, 0));
        go(); chk("halt_c4", pk(0, 0, 0, 2'b00, 0, 0, 0, 1));
        IM_RDY = 1;
        go(); chk("halt_c5", pk(0, 0, 0, 2'b00, 0, 0, 0, 1));
        IM_RDY = 0; RST = 1;
        go(); chk("halt_rst", pk(0, 0, 0, 2'b00, 0, 0, 0, 0));
        RST = 0; #1;
        chk("halt_after_rst", pk(1, 0, 0, 2'b00, 0, 0, 0, 0));

        // PC wrap: branch to 0xFFFF then NOP
        rst_seq();
        IM_DATA = 32'h41FF_FFFE; STAT = 4'h1; IM_RDY = 1;
        go(); IM_RDY = 0; go(); go();
        chk("wrap_bra", pk(1, 16'hFFFF, 0, 2'b00, 0, 0, 0, 0));
        IM_DATA = 32'h0000_0000; IM_RDY = 1;
        go(); IM_RDY = 0; go(); go();
        chk("wrap_nop", pk(1, 16'h0000, 0, 2'b00, 0, 0, 0, 0));

        // reset during writeback
        rst_seq();
        IM_DATA = 32'h2000_0001; IM_RDY = 1;
        go(); IM_RDY = 0; go(); go();
        chk("wb_before_rst", pk(0, 0, 1, 2'b10, 1, 0, 0, 0));
        RST = 1;
        go(); chk("wb_rst", pk(0, 0, 0, 2'b00, 0, 0, 0, 0));
        RST = 0; #1;
        chk("wb_rst_fetch", pk(1, 0, 0, 2'b00, 0, 0, 0, 0));
        chk_val("wb_rst_ir", IR, 0);

        // randomized program against the per-instruction timeline model
        rst_seq();
        pc_m = 0;
        for (int k = 0; k < 400; k++) begin
            for (int s = int'($urandom_range(0, 2)); s > 0; s--) begin
                chk("rnd_stall", pk(1, pc_m, 0, 2'b00, 0, 0, 0, 0));
                IM_DATA = $urandom();
                go();
            end
            op = 4'($urandom_range(0, 15));
            if (op == 4'h8 && $urandom_range(0, 5) != 0) op = 4'h4;
            r = $urandom();
            instr = {op, r[27:0]};
            st = 4'($urandom_range(0, 15));
            alu = op == 4'h1 || op == 4'h2;
            aop = op == 4'h1 ? 2'b01 : 2'b10;
            chk("rnd_fetch", pk(1, pc_m, 0, 2'b00, 0, 0, 0, 0));
            IM_DATA = instr; STAT = st; IM_RDY = 1;
            go();
            IM_RDY = 0; IM_DATA = $urandom();
            chk_val("rnd_ir", IR, instr);
            chk("rnd_decode", pk(0, pc_m, 0, 2'b00, 0, 0, 0, 0));
            go();
            chk("rnd_exec", pk(0, pc_m, 0, alu ? aop : 2'b00, 0, op == 4'h1, alu, 0));
            go();
            if (alu) begin
                chk("rnd_wb", pk(0, pc_m, 1, aop, 1, op == 4'h1, 0, 0));
                go();
                pc_m = pc_m + 1;
            end else if (op == 4'h4) begin
                pc_m = (instr[27:24] & st) != 0 ? pc_m + 16'd1 + instr[15:0] : pc_m + 16'd1;
            end else if (op == 4'h8) begin
                for (int h = 0; h < 2; h++) begin
                    chk("rnd_halt", pk(0, pc_m, 0, 2'b00, 0, 0, 0, 1));
                    IM_RDY = 1;
                    go();
                end
                IM_RDY = 0; RST = 1;
                go();
                RST = 0; #1;
                pc_m = 0;
            end else begin
                pc_m = pc_m + 1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule

// File: doc/sisc_seq.md
SISC_SEQ -- requirements
Module: sisc_seq

Interface
REQ-001 The block SHALL have port CLK, input, 1 bit: single system clock, all state updates on rising edge.
REQ-002 The block SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-003 The block SHALL have port IM_RDY, input, 1 bit: instruction memory data valid this cycle.
REQ-004 The block SHALL have port IM_DATA, input, 32 bits: instruction word, valid when IM_RDY=1.
REQ-005 The block SHALL have port STAT, input, 4 bits: registered condition codes from the status register.
REQ-006 The block SHALL have port IM_REQ, output, 1 bit: instruction fetch request.
REQ-007 The block SHALL have port PC, output, 16 bits: fetch address and current program counter.
REQ-008 The block SHALL have port IR, output, 32 bits: latched instruction; drives register-file read addresses, immediate and MM fields.
REQ-009 The block SHALL have port RF_WE, output, 1 bit: register-file write enable.
REQ-010 The block SHALL have port ALU_OP, output, 2 bits: 00 pass, 01 reg-reg, 10 reg-imm.
REQ-011 The block SHALL have port WB_SEL, output, 1 bit: 1 = ALU result, 0 = constant.
REQ-012 The block SHALL have port RD_SEL, output, 1 bit: 1 = IR[15:12], 0 = IR[19:16].
REQ-013 The block SHALL have port STAT_EN, output, 1 bit: status register load enable.
REQ-014 The block SHALL have port HALTED, output, 1 bit: processor stopped.

Function
REQ-015 The block SHALL implement states FETCH, DECODE, EXECUTE, WRITEBACK and HALT.
REQ-016 FETCH SHALL assert IM_REQ with PC stable and wait without limit while IM_RDY=0.
REQ-017 When IM_RDY=1 in FETCH, IR SHALL load IM_DATA on that edge and the next state SHALL be DECODE.
REQ-018 DECODE SHALL last exactly 1 cycle and SHALL assert no datapath enables.
REQ-019 Opcode IR[31:28]=0x1 (ALU reg-reg) SHALL set ALU_OP=01 and RD_SEL=1 in EXECUTE and WRITEBACK, and SHALL assert STAT_EN in EXECUTE only.
REQ-020 Opcode 0x2 (ALU reg-imm) SHALL behave as REQ-019 except ALU_OP=10 and RD_SEL=0.
REQ-021 WRITEBACK SHALL assert RF_WE=1 and WB_SEL=1 for exactly 1 cycle, then PC SHALL become PC+1 and the next state SHALL be FETCH.
REQ-022 Opcode 0x4 (BRA) SHALL be evaluated in EXECUTE: taken iff (IR[27:24] & STAT)!=0; taken PC = PC+1+IR[15:0]; not taken PC = PC+1; next state FETCH; no WRITEBACK.
REQ-023 Opcode 0x0 and every undefined opcode SHALL be a NOP: EXECUTE does PC+1 then FETCH, with no enables asserted.
REQ-024 Opcode 0x8 (HALT) SHALL enter HALT from EXECUTE. HALT SHALL hold HALTED=1, IM_REQ=0, PC unchanged and all enables 0 until reset.
REQ-025 PC arithmetic SHALL be 16-bit modulo: 0xFFFF+1 wraps to 0x0000, and branch offsets wrap likewise.
REQ-026 Latency with IM_RDY tied to 1 SHALL be: ALU instruction 4 cycles; BRA, NOP and HALT 3 cycles.
REQ-027 RF_WE and STAT_EN SHALL never be asserted in the same cycle.
REQ-028 Outputs outside the states named above SHALL be ALU_OP=00, WB_SEL=0, RD_SEL=0.

Reset
REQ-029 RST=1 at a rising edge SHALL force state FETCH, PC=0x0000, IR=0, HALTED=0, and RF_WE, STAT_EN, ALU_OP, WB_SEL and RD_SEL all 0, overriding any in-progress state, including HALT and a pending fetch.
REQ-030 IM_REQ SHALL be 0 while RST=1 and SHALL assert in the first cycle after RST deasserts.

Structure
REQ-031 A shared package sisc_pkg SHALL hold the opcode constants (NOP, ALU_RR, ALU_RI, BRA, HALT), the ALU_OP encodings and the state enumeration.
REQ-032 The PC register, incrementer and branch adder SHALL be one sub-module, pc_unit, with inputs ld_inc, ld_br, offset and rst.
REQ-033 The next-state logic and output decode SHALL be combinational from the state register and IR only.

Verification
REQ-034 Reset, then IM_DATA=0x1120_3000 with IM_RDY=1 -> IR loaded at cycle 1; ALU_OP=01 and STAT_EN=1 at cycle 3; RF_WE=1, WB_SEL=1, RD_SEL=1 at cycle 4; PC=1 at cycle 5.
REQ-035 BRA 0x4100_0005 with STAT=0001 -> PC goes 0x0000 to 0x0006; with STAT=0010 -> PC goes to 0x0001, RF_WE never asserted.
REQ-036 IM_RDY held low 5 cycles in FETCH -> IM_REQ=1 and PC stable for all 5 cycles; IR loads on the first IM_RDY=1 edge.
REQ-037 HALT 0x8000_0000 -> HALTED=1 from cycle 4; then RST pulsed for 1 cycle -> PC=0, HALTED=0, IM_REQ=1 on the next cycle.
REQ-038 PC preset to 0xFFFF via a BRA, then a NOP -> PC wraps to 0x0000.
REQ-039 RST asserted during WRITEBACK -> RF_WE=0 in the following cycle and state is FETCH.
